iq_inst_extract: RTL
====================

// Module: iq_inst_extract
// PURPOSE
//  Downstream consumer of the instruction queue. Pops one ICACHE line at a time from the queue.
//  Splits the line into 32-bit instructions and hands them, one per cycle with their PC, to decode.
//  Owns the fetch-redirect path: on redirect it discards held state and flushes the queue.
// PARAMETERS
//  LINE_W    ICACHE_LINE_SIZE (128)  width of one queue entry / cache line
//  INST_W    32                      instruction width; WORDS = LINE_W/INST_W (4), power of two
//  PC_W      32                      program counter width
//  RESET_PC  32'h0000_0000           PC of first instruction after reset
// PORTS
//  clk_i          in   1       clock; single clock domain
//  rst_i          in   1       reset, synchronous, active-high
//  iq_empty_i     in   1       queue empty flag
//  iq_wr_i        in   1       queue write strobe, snooped; queue gives write priority over read
//  iq_data_i      in   LINE_W  queue read data, valid the cycle after an accepted read
//  iq_rd_o        out  1       queue read request
//  iq_flush_o     out  1       one-cycle pulse; top level ANDs its inverse into the queue's rst_ni
//  redirect_i     in   1       branch/exception redirect
//  redirect_pc_i  in   PC_W    redirect target; bits [1:0] are 0
//  inst_o         out  INST_W  instruction to decode
//  pc_o           out  PC_W    PC of inst_o
//  valid_o        out  1       inst_o/pc_o valid
//  ready_i        in   1       decode accepts; transfer = valid_o & ready_i
// BEHAVIOUR
//  Reset: state=EMPTY, valid_o=0, iq_rd_o=0, iq_flush_o=0, pc_q=RESET_PC, slot_q=RESET_PC[log2(WORDS)+1:2].
//  iq_rd_o (combinational) = !iq_empty_i & !iq_wr_i & !redirect_i & (state==EMPTY | last_xfer).
//    last_xfer = (state==SERVE) & valid_o & ready_i & (slot_q==WORDS-1).
//    - A read is issued only when the queue accepts it; that is why iq_wr_i gates the read.
//  States:
//    EMPTY -> WAIT when iq_rd_o; otherwise stays in EMPTY.
//    WAIT  -> SERVE next cycle.
//      - line_q <= iq_data_i (queue output is registered: 1-cycle read latency).
//    SERVE -> handling of a transfer:
//      - valid_o=1; inst_o = line_q[slot_q*INST_W +: INST_W]; pc_o = pc_q.
//      - On transfer: pc_q += 4 (wraps mod 2^PC_W); slot_q += 1 (wraps mod WORDS).
//      - Last-slot transfer goes to WAIT if iq_rd_o, else to EMPTY.
//      - No transfer: hold all outputs stable (AXI-style, no retraction).
//  Throughput: WORDS instructions per WORDS+1 cycles when the queue never runs dry.
//    - The WAIT cycle is the only bubble.
//  Redirect (any state, highest priority below reset):
//    - state <= EMPTY; valid_o <= 0 next cycle; pc_q <= redirect_pc_i.
//    - slot_q <= redirect_pc_i[log2(WORDS)+1:2]; iq_flush_o <= 1 for one cycle.
//    - A same-cycle transfer still completes; it is decode's to kill.
//    - A line in flight (WAIT) is discarded.
//    - iq_rd_o is held low in the redirect cycle and in the flush cycle.
//  First line after reset/redirect: service starts at slot_q, not slot 0.
//    - Earlier words in that line are skipped.
//  Reset mid-operation: returns to reset values next edge; in-flight line dropped.
//  valid_o, state, line_q, pc_q and slot_q are registers; inst_o is a mux off line_q.
// STRUCTURE
//  lagarto0_pkg additions:
//    - INST_SIZE=32, IQ_WORDS_PER_LINE=ICACHE_LINE_SIZE/INST_SIZE, IQ_SLOT_SIZE=$clog2(IQ_WORDS_PER_LINE).
//    - Localparams for state encoding EX_EMPTY/EX_WAIT/EX_SERVE.
//  Single module; the word mux and FSM are inline, and no sub-module is warranted.
// TESTING (LINE_W=128, RESET_PC=0)
//  1. Queue holds line 128'h00000013_00100093_00200113_00300193, ready_i=1 after reset:
//     - iq_rd_o pulses once, then one WAIT cycle.
//     - Outputs: inst/pc 00300193/0, 00200113/4, 00100093/8, 00000013/C on consecutive cycles.
//  2. Two lines queued, ready_i=1:
//     - iq_rd_o re-asserts on the pc=C transfer.
//     - pc 10 appears 2 cycles after pc C (exactly one bubble).
//  3. iq_wr_i=1 while EMPTY and !iq_empty_i:
//     - iq_rd_o stays 0 until iq_wr_i drops.
//     - No extra or lost line; the instruction sequence matches test 1.
//  4. ready_i=0 for 3 cycles at pc=4:
//     - valid_o=1, inst_o=00200113 and pc_o=4 held stable.
//     - pc=8 follows on the cycle ready_i returns.
//  5. redirect_i with redirect_pc_i=32'h108 while in WAIT:
//     - iq_flush_o=1 for one cycle and the in-flight line is dropped.
//     - Next line served from slot 2: first pc_o=108, then 10C, then a read.
//  6. rst_i asserted in SERVE at slot 1 -> next cycle valid_o=0, iq_rd_o=0, pc_q=0, state EMPTY.
//  Checker: scoreboard of popped lines vs emitted (inst,pc); assert valid_o stable while !ready_i.

Source files
------------

// File: rtl/iq_inst_extract_pkg.sv
// -----------------------------------------------------------------------------
// iq_inst_extract_pkg
//   Shared constants and types for the instruction-queue extractor:
//   - cache line / instruction geometry and the derived slot index width
//   - state encoding of the extractor FSM
// -----------------------------------------------------------------------------
package iq_inst_extract_pkg;

  localparam int ICACHE_LINE_SIZE  = 128;
  localparam int INST_SIZE         = 32;
  localparam int IQ_WORDS_PER_LINE = ICACHE_LINE_SIZE / INST_SIZE;
  localparam int IQ_SLOT_SIZE      = $clog2(IQ_WORDS_PER_LINE);

  // EMPTY : no line held, waiting to pop one from the queue
  // WAIT  : read issued, queue data arrives this cycle
  // SERVE : line held, handing out one instruction per transfer
  typedef enum logic [1:0] {
    EX_EMPTY = 2'd0,
    EX_WAIT  = 2'd1,
    EX_SERVE = 2'd2
  } ex_state_e;

endpackage : iq_inst_extract_pkg

// File: rtl/iq_inst_extract.sv
// -----------------------------------------------------------------------------
// iq_inst_extract
//   Pops one cache line at a time from the instruction queue, splits it into
//   INST_W-bit instructions and presents them to decode one per cycle with
//   their PC. Owns the fetch-redirect path: a redirect drops any held or
//   in-flight line, reloads the PC and pulses a queue flush.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   iq_empty_i     queue empty flag
//   iq_wr_i        queue write strobe (writes win over reads in the queue)
//   iq_data_i      queue read data, valid the cycle after an accepted read
//   iq_rd_o        queue read request (combinational)
//   iq_flush_o     one-cycle queue flush pulse, the cycle after a redirect
//   redirect_i     branch/exception redirect
//   redirect_pc_i  redirect target PC (bits [1:0] are zero)
//   inst_o         instruction to decode
//   pc_o           PC of inst_o
//   valid_o        inst_o/pc_o valid
//   ready_i        decode accepts; a transfer is valid_o & ready_i
// -----------------------------------------------------------------------------
module iq_inst_extract
  import iq_inst_extract_pkg::*;
#(
  parameter int              LINE_W   = ICACHE_LINE_SIZE,
  parameter int              INST_W   = INST_SIZE,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iq_empty_i,
  input  logic              iq_wr_i,
  input  logic [LINE_W-1:0] iq_data_i,
  output logic              iq_rd_o,
  output logic              iq_flush_o,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int WORDS  = LINE_W / INST_W;
  localparam int SLOT_W = $clog2(WORDS);

  ex_state_e             state_q, state_d;
  logic                  valid_q;
  logic                  flush_q;
  logic [LINE_W-1:0]     line_q;
  logic [PC_W-1:0]       pc_q;
  logic [SLOT_W-1:0]     slot_q;

  logic                  xfer;
  logic                  last_xfer;
  logic                  rd;

  assign xfer      = valid_q & ready_i;
  assign last_xfer = (state_q == EX_SERVE) & xfer & (slot_q == SLOT_W'(WORDS - 1));

  // Only request a read the queue will actually honour: a same-cycle write
  // would win arbitration, and a read during redirect/flush/reset would pop a
  // line that is about to be discarded.
  assign rd = ~iq_empty_i & ~iq_wr_i & ~redirect_i & ~flush_q & ~rst_i &
              ((state_q == EX_EMPTY) | last_xfer);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      EX_EMPTY: if (rd) state_d = EX_WAIT;
      EX_WAIT:  state_d = EX_SERVE;
      EX_SERVE: if (last_xfer) state_d = rd ? EX_WAIT : EX_EMPTY;
      default:  state_d = EX_EMPTY;
    endcase
    if (redirect_i) state_d = EX_EMPTY;
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EX_EMPTY;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= RESET_PC;
      slot_q  <= RESET_PC[SLOT_W+1:2];
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == EX_SERVE);
      flush_q <= redirect_i;
      // A transfer coinciding with a redirect still completes on the decode
      // side; the redirect target simply overrides the PC advance.
      if (redirect_i) begin
        pc_q   <= redirect_pc_i;
        slot_q <= redirect_pc_i[SLOT_W+1:2];
      end else if (xfer) begin
        pc_q   <= pc_q + PC_W'(4);
        slot_q <= slot_q + SLOT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer
  // ---------------------------------------------------------------------------
  // NOTE: the line buffer carries no reset; valid_q qualifies its contents, so
  // resetting it would only add reset fan-out to a wide data register.
  always_ff @(posedge clk_i) begin
    if (state_q == EX_WAIT) line_q <= iq_data_i;
  end

  // Slot counter starts at the PC's word offset, so the first line after reset
  // or redirect skips the words that precede the target.
  assign inst_o     = line_q[INST_W*int'(slot_q) +: INST_W];
  assign pc_o       = pc_q;
  assign valid_o    = valid_q;
  assign iq_rd_o    = rd;
  assign iq_flush_o = flush_q;

endmodule : iq_inst_extract
